mb_rx_deser_ctrl: RTL and testbench

- Capture scheduler for the mainband RX lane deserializer, in the pll_clk domain.
- Generates the one-cycle ser_valid strobe once per 32-bit word, after an alignment window, for a programmed burst of words.
- Tracks whether the mainband side has consumed each captured word, via an already-synchronized ack. Flags overrun when a new capture would overwrite an unconsumed word.
- Reports busy, burst completion and word count to the mainband RX controller.

---
 rtl/mb_rx_deser_ctrl.sv | 137 +++++++++++++
 tb/tb_mb_rx_deser_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mb_rx_deser_ctrl.sv
// ============================================================================
// mb_rx_deser_ctrl : mainband RX deserializer capture scheduler (pll_clk).
// Optional MB_DESER_OVF_CNT_EN adds an 8-bit saturating overrun counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mb_rx_deser_ctrl #(
  parameter int WORD_CYCLES  = 16,
  parameter int ALIGN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             pll_clk,
  input  logic             i_rst_n,
  input  logic             i_rx_en,
  input  logic [CNT_W-1:0] i_burst_len,
  input  logic             i_word_ack,
  output logic             o_ser_valid,
  output logic             o_busy,
  output logic             o_burst_done,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_word_cnt
`ifdef MB_DESER_OVF_CNT_EN
  ,
  output logic [7:0]       o_ovf_cnt
`endif
);

  // One counter serves both the ALIGN dwell and the RUN word phase.
  localparam int c_PH_MAX = (WORD_CYCLES > ALIGN_CYCLES) ? WORD_CYCLES : ALIGN_CYCLES;
  localparam int c_PH_W   = $clog2(c_PH_MAX);
  localparam logic [c_PH_W-1:0] c_WORD_LAST  = c_PH_W'(WORD_CYCLES - 1);
  localparam logic [c_PH_W-1:0] c_ALIGN_LAST = c_PH_W'(ALIGN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_PH_W-1:0]  r_phase;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_word_cnt;
  logic               r_pending;
  logic               r_ser_valid;
  logic               r_busy;
  logic               r_burst_done;
  logic               r_overflow;
  logic               w_start;
  logic               w_last_word;
  logic               w_ovf_evt;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_start     = (r_state == S_IDLE) && i_rx_en;
  assign w_cnt_inc   = r_word_cnt + CNT_W'(1);
  assign w_last_word = (r_len != '0) && (w_cnt_inc == r_len);
  // Bookkeeping is resolved in the strobe cycle so a coincident ack is visible.
  assign w_ovf_evt   = r_ser_valid && r_pending && !i_word_ack;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_rx_en) w_next = S_ALIGN;
      S_ALIGN: begin
        if (!i_rx_en)                    w_next = S_IDLE;
        else if (r_phase == c_ALIGN_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (!i_rx_en)                        w_next = S_IDLE;
        else if (r_ser_valid && w_last_word) w_next = S_DONE;
      end
      S_DONE:  if (!i_rx_en) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pll_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_pending    <= 1'b0;
      r_ser_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_burst_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_ser_valid  <= (r_state == S_RUN) && i_rx_en && (r_phase == c_WORD_LAST);
      r_busy       <= (w_next == S_ALIGN) || (w_next == S_RUN);
      r_burst_done <= (r_state == S_RUN) && (w_next == S_DONE);

      if (r_state != w_next)                                r_phase <= '0;
      else if (r_state == S_ALIGN)                          r_phase <= r_phase + c_PH_W'(1);
      else if (r_state == S_RUN && r_phase == c_WORD_LAST)  r_phase <= '0;
      else if (r_state == S_RUN)                            r_phase <= r_phase + c_PH_W'(1);

      if (w_start) begin
        r_len      <= i_burst_len;
        r_word_cnt <= '0;
        r_overflow <= 1'b0;
        r_pending  <= 1'b0;
      end else if (r_ser_valid) begin
        r_word_cnt <= w_cnt_inc;
        r_pending  <= 1'b1;
        if (w_ovf_evt) r_overflow <= 1'b1;
      end else if (i_word_ack) begin
        r_pending  <= 1'b0;
      end
    end
  end

`ifdef MB_DESER_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge pll_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          r_ovf_cnt <= 8'd0;
    else if (w_start)                      r_ovf_cnt <= 8'd0;
    else if (w_ovf_evt && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
  end

  assign o_ovf_cnt = r_ovf_cnt;
`endif

  assign o_ser_valid  = r_ser_valid;
  assign o_busy       = r_busy;
  assign o_burst_done = r_burst_done;
  assign o_overflow   = r_overflow;
  assign o_word_cnt   = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mb_rx_deser_ctrl.sv
// ============================================================================
// tb_mb_rx_deser_ctrl : randomized bench with timeline reference model for
// mb_rx_deser_ctrl (16-bit and 4-bit counter instances driven in lockstep).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mb_rx_deser_ctrl;

  localparam int WC = 16;
  localparam int AC = 4;
  localparam int M_IDLE = 0, M_ALIGN = 1, M_RUN = 2, M_DONE = 3;

  logic        pll_clk = 1'b0;
  logic        rst_n, rx_en, word_ack;
  logic [15:0] burst_len;
  logic        sv_a, busy_a, done_a, ovf_a;
  logic [15:0] cnt_a;
  logic        sv_b, busy_b, done_b, ovf_b;
  logic [3:0]  cnt_b;
`ifdef MB_DESER_OVF_CNT_EN
  logic [7:0]  ovfc_a, ovfc_b;
`endif

  always #5 pll_clk = ~pll_clk;

  mb_rx_deser_ctrl #(.WORD_CYCLES(WC), .ALIGN_CYCLES(AC), .CNT_W(16)) u_dut (
    .pll_clk(pll_clk), .i_rst_n(rst_n), .i_rx_en(rx_en), .i_burst_len(burst_len),
    .i_word_ack(word_ack), .o_ser_valid(sv_a), .o_busy(busy_a), .o_burst_done(done_a),
    .o_overflow(ovf_a), .o_word_cnt(cnt_a)
`ifdef MB_DESER_OVF_CNT_EN
    , .o_ovf_cnt(ovfc_a)
`endif
  );

  mb_rx_deser_ctrl #(.WORD_CYCLES(WC), .ALIGN_CYCLES(AC), .CNT_W(4)) u_dut4 (
    .pll_clk(pll_clk), .i_rst_n(rst_n), .i_rx_en(rx_en), .i_burst_len(burst_len[3:0]),
    .i_word_ack(word_ack), .o_ser_valid(sv_b), .o_busy(busy_b), .o_burst_done(done_b),
    .o_overflow(ovf_b), .o_word_cnt(cnt_b)
`ifdef MB_DESER_OVF_CNT_EN
    , .o_ovf_cnt(ovfc_b)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: position on the burst timeline plus burst bookkeeping.
  int m_mode, m_t, m_len, m_cnt, m_ovfc, m_since;
  bit m_pend, m_ovf;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_strobe();
    return (m_mode == M_RUN) && (m_t > 0) && ((m_t % WC) == 0);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_t = 0; m_len = 0; m_cnt = 0; m_ovfc = 0; m_since = 100;
    m_pend = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic go(input int mode);
    m_mode = mode;
    m_t    = 0;
  endtask

  task automatic check_outputs();
    bit exp_busy;
    exp_busy = (m_mode == M_ALIGN) || (m_mode == M_RUN);
    chk("ser_valid",    32'(sv_a),   32'(m_strobe()));
    chk("busy",         32'(busy_a), 32'(exp_busy));
    chk("burst_done",   32'(done_a), 32'((m_mode == M_DONE) && (m_t == 0)));
    chk("overflow",     32'(ovf_a),  32'(m_ovf));
    chk("word_cnt",     32'(cnt_a),  32'(m_cnt % 65536));
    chk("w4_ser_valid", 32'(sv_b),   32'(m_strobe()));
    chk("w4_busy",      32'(busy_b), 32'(exp_busy));
    chk("w4_word_cnt",  32'(cnt_b),  32'(m_cnt % 16));
    chk("w4_overflow",  32'(ovf_b),  32'(m_ovf));
`ifdef MB_DESER_OVF_CNT_EN
    chk("ovf_cnt",      32'(ovfc_a), 32'(m_ovfc));
    chk("w4_ovf_cnt",   32'(ovfc_b), 32'(m_ovfc));
`endif
  endtask

  // One clock: check the current cycle, drive inputs, advance the model.
  // ackpol: 0 none, 1 two cycles after strobe, 2 with strobe, 3 random, 4 with 2nd strobe only.
  task automatic cycle(input bit rx, input int ackpol);
    bit s, ack;
    check_outputs();
    s = m_strobe();
    if (s) m_since = 0; else if (m_since < 100) m_since++;
    case (ackpol)
      1:       ack = (m_since == 2);
      2:       ack = s;
      3:       ack = ($urandom_range(0, 2) == 0);
      4:       ack = s && (m_cnt == 1);
      default: ack = 1'b0;
    endcase
    rx_en    = rx;
    word_ack = ack;
    if (m_mode == M_IDLE) begin
      if (rx) begin
        m_len = int'(burst_len); m_cnt = 0; m_ovf = 1'b0; m_pend = 1'b0; m_ovfc = 0;
        go(M_ALIGN);
      end else if (ack) m_pend = 1'b0;
    end else begin
      if (s) begin
        if (m_pend && !ack) begin
          m_ovf = 1'b1;
          if (m_ovfc < 255) m_ovfc++;
        end
        m_pend = 1'b1;
        m_cnt++;
      end else if (ack) m_pend = 1'b0;
      if (!rx) go(M_IDLE);
      else if (m_mode == M_ALIGN && m_t == AC - 1) go(M_RUN);
      else if (m_mode == M_RUN && s && m_len != 0 && (m_cnt % 65536) == m_len) go(M_DONE);
      else m_t++;
    end
    @(negedge pll_clk);
  endtask

  initial begin
    rst_n = 1'b0; rx_en = 1'b0; word_ack = 1'b0; burst_len = 16'd0;
    model_reset();
    repeat (2) @(negedge pll_clk);
    check_outputs();
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 0);

    // Burst of 3, acks two cycles after each strobe, rx held high through DONE
    burst_len = 16'd3;
    repeat (100) cycle(1'b1, 1);
    chk("t1_final_cnt", 32'(cnt_a), 32'd3);
    chk("t1_no_ovf", 32'(ovf_a), 32'd0);
    chk("t1_idle_in_done", 32'(busy_a), 32'd0);
    repeat (3) cycle(1'b0, 1);

    // Continuous, never acked
    burst_len = 16'd0;
    repeat (75) cycle(1'b1, 0);
    chk("t2_cnt", 32'(cnt_a), 32'd4);
    chk("t2_ovf", 32'(ovf_a), 32'd1);
`ifdef MB_DESER_OVF_CNT_EN
    chk("t2_ovf_cnt", 32'(ovfc_a), 32'd3);
`endif
    repeat (3) cycle(1'b0, 0);

    // Ack coincident with the 2nd strobe keeps pending set
    burst_len = 16'd4;
    for (int i = 0; i < 200 && !(m_cnt == 2 && m_since == 1); i++) cycle(1'b1, 4);
    chk("t3_ovf_after_ack", 32'(ovf_a), 32'd0);
    for (int i = 0; i < 200 && m_mode != M_DONE; i++) cycle(1'b1, 4);
    chk("t3_pending_kept", 32'(ovf_a), 32'd1);
    repeat (3) cycle(1'b0, 0);

    // Abort at the last phase of word 2
    burst_len = 16'd5;
    for (int i = 0; i < 200 && !(m_mode == M_RUN && m_t == 2 * WC - 1); i++) cycle(1'b1, 1);
    cycle(1'b0, 1);
    chk("t4_no_strobe", 32'(sv_a), 32'd0);
    chk("t4_cnt_hold", 32'(cnt_a), 32'd1);
    repeat (3) cycle(1'b0, 1);
    chk("t4_no_done", 32'(done_a), 32'd0);
    cycle(1'b1, 1);
    chk("t4_restart_busy", 32'(busy_a), 32'd1);
    chk("t4_restart_cnt", 32'(cnt_a), 32'd0);
    repeat (30) cycle(1'b1, 1);
    repeat (3) cycle(1'b0, 1);

    // Counter wrap on the 4-bit instance, then asynchronous reset inside a strobe
    burst_len = 16'd0;
    for (int i = 0; i < 400 && m_cnt < 17; i++) cycle(1'b1, 2);
    chk("t5_wrap4", 32'(cnt_b), 32'd1);
    chk("t5_cnt16", 32'(cnt_a), 32'd17);
    for (int i = 0; i < 40 && !m_strobe(); i++) cycle(1'b1, 2);
    chk("t5_in_strobe", 32'(sv_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge pll_clk);
    rx_en = 1'b0;
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 0);

    // Randomized bursts with random acks, aborts and mid-burst length changes
    for (int b = 0; b < 30; b++) begin
      int len_cyc;
      burst_len = 16'($urandom_range(0, 5));
      len_cyc   = $urandom_range(20, 120);
      for (int i = 0; i < len_cyc; i++) begin
        bit rx;
        rx = ($urandom_range(0, 63) != 0);
        if ($urandom_range(0, 7) == 0) burst_len = 16'($urandom_range(0, 5));
        cycle(rx, 3);
      end
      repeat (2) cycle(1'b0, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
